wb_b3_burst_master: RTL and testbench

- Wishbone B3 bus master sitting directly upstream of the on-chip RAM slave. Converts simple line requests from a cache/DMA client into B3 incrementing-wrap bursts or classic single cycles.
- Streams write data in and read data out beat by beat.
- Reports completion or error once per request.

---
 rtl/wb_b3_pkg.sv | 31 +++
 rtl/wb_b3_adr_gen.sv | 23 ++
 rtl/wb_b3_burst_master.sv | 156 +++++++++++++++
 tb/tb_wb_b3_burst_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_b3_pkg.sv
// Wishbone B3 cycle-type/burst-type encodings and the master FSM state type;
// shared with slaves that decode the same burst encoding.
package wb_b3_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } mst_state_e;

   // Request length code to number of beats: 1, 4, 8, 16.
   function automatic logic [4:0] beat_count(input logic [1:0] len);
      case (len)
         2'b00:   beat_count = 5'd1;
         2'b01:   beat_count = 5'd4;
         2'b10:   beat_count = 5'd8;
         default: beat_count = 5'd16;
      endcase
   endfunction

endpackage

// File: rtl/wb_b3_adr_gen.sv
// Next word address for a B3 burst: wraps inside a 4/8/16-word window per bte,
// linear increment otherwise. Operates on word addresses (byte address >> 2).
module wb_b3_adr_gen
   import wb_b3_pkg::*;
#(
   parameter int aw = 32
) (
   input  logic [aw-3:0] wadr_i,
   input  logic [1:0]    bte_i,
   output logic [aw-3:0] wadr_o
);

   always_comb begin
      wadr_o = wadr_i;
      case (bte_i)
         BTE_WRAP4:  wadr_o[1:0] = wadr_i[1:0] + 2'd1;
         BTE_WRAP8:  wadr_o[2:0] = wadr_i[2:0] + 3'd1;
         BTE_WRAP16: wadr_o[3:0] = wadr_i[3:0] + 4'd1;
         default:    wadr_o      = wadr_i + (aw-2)'(1);
      endcase
   end

endmodule

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst master: line requests to wrap bursts or classic singles.
// Optional per-beat ack timeout enabled by WB_B3_BURST_MASTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a request (ready held low for the first cycle after reset)
// BUS     | cyc asserted, beats issued until last ack or error/retry/timeout
// RESP    | one-cycle done_o pulse, err_o qualifies it
module wb_b3_burst_master
   import wb_b3_pkg::*;
#(
   parameter int dw             = 32,
   parameter int aw             = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          req_we_i,
   input  logic [aw-1:0] req_adr_i,
   input  logic [1:0]    req_len_i,
   input  logic [3:0]    req_sel_i,
   input  logic [dw-1:0] wdat_i,
   input  logic          wdat_valid_i,
   output logic          wdat_ready_o,
   output logic [dw-1:0] rdat_o,
   output logic          rdat_valid_o,
   output logic          done_o,
   output logic          err_o,
   output logic [aw-1:0] wbm_adr_o,
   output logic [dw-1:0] wbm_dat_o,
   output logic [3:0]    wbm_sel_o,
   output logic          wbm_we_o,
   output logic [1:0]    wbm_bte_o,
   output logic [2:0]    wbm_cti_o,
   output logic          wbm_cyc_o,
   output logic          wbm_stb_o,
   input  logic          wbm_ack_i,
   input  logic          wbm_err_i,
   input  logic          wbm_rty_i,
   input  logic [dw-1:0] wbm_dat_i
);

   mst_state_e    state_q;
   logic          rdy_q, cyc_q, we_q, err_q, rdat_valid_q;
   logic [1:0]    len_q;
   logic [3:0]    sel_q;
   logic [4:0]    cnt_q;
   logic [aw-3:0] wadr_q, wadr_nxt;
   logic [dw-1:0] rdat_q;
   logic          stb, beat_ok, beat_abort, timeout;
   logic          unused_adr_lsb;

   assign unused_adr_lsb = ^req_adr_i[1:0];

   assign stb        = cyc_q & (we_q ? wdat_valid_i : 1'b1);
   // Error, retry and timeout all abort; any of them overrides a same-cycle ack.
   assign beat_abort = stb & (wbm_err_i | wbm_rty_i | timeout);
   assign beat_ok    = stb & wbm_ack_i & ~beat_abort;

   wb_b3_adr_gen #(.aw(aw)) u_adr_gen (
      .wadr_i (wadr_q),
      .bte_i  (len_q),
      .wadr_o (wadr_nxt)
   );

`ifdef WB_B3_BURST_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_q;

   assign timeout = stb & ~wbm_ack_i & (to_q == '0);

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)               to_q <= TW'(TIMEOUT_CYCLES - 1);
      else if (!stb || wbm_ack_i)    to_q <= TW'(TIMEOUT_CYCLES - 1);
      else if (to_q != '0)           to_q <= to_q - TW'(1);
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q      <= ST_IDLE;
         rdy_q        <= 1'b0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         len_q        <= 2'b00;
         sel_q        <= 4'h0;
         cnt_q        <= 5'd0;
         wadr_q       <= '0;
         rdat_q       <= '0;
         rdat_valid_q <= 1'b0;
      end else begin
         rdat_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               rdy_q <= 1'b1;
               if (req_valid_i && rdy_q) begin
                  rdy_q   <= 1'b0;
                  cyc_q   <= 1'b1;
                  we_q    <= req_we_i;
                  len_q   <= req_len_i;
                  sel_q   <= (req_len_i == 2'b00) ? req_sel_i : 4'hf;
                  wadr_q  <= req_adr_i[aw-1:2];
                  cnt_q   <= beat_count(req_len_i);
                  err_q   <= 1'b0;
                  state_q <= ST_BUS;
               end
            end
            ST_BUS: begin
               if (beat_abort) begin
                  cyc_q   <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else if (beat_ok) begin
                  wadr_q       <= wadr_nxt;
                  cnt_q        <= cnt_q - 5'd1;
                  rdat_q       <= wbm_dat_i;
                  rdat_valid_q <= ~we_q;
                  if (cnt_q == 5'd1) begin
                     cyc_q   <= 1'b0;
                     state_q <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               err_q   <= 1'b0;
               rdy_q   <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o  = rdy_q;
   assign wdat_ready_o = beat_ok & we_q;
   assign rdat_o       = rdat_q;
   assign rdat_valid_o = rdat_valid_q;
   assign done_o       = (state_q == ST_RESP);
   assign err_o        = err_q;

   assign wbm_adr_o = {wadr_q, 2'b00};
   assign wbm_dat_o = (cyc_q & we_q) ? wdat_i : '0;
   assign wbm_sel_o = sel_q;
   assign wbm_we_o  = we_q;
   assign wbm_bte_o = len_q;
   assign wbm_cti_o = (len_q == 2'b00) ? CTI_CLASSIC :
                      (cnt_q == 5'd1)  ? CTI_EOB : CTI_INCR;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb;

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Directed bench for wb_b3_burst_master against a zero-wait RAM slave model
// (64 words at 0x00-0xFF, error response outside that window).
`timescale 1ns/1ps
module tb_wb_b3_burst_master;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid_i = 0, req_we_i = 0;
   logic [31:0] req_adr_i = 0;
   logic [1:0]  req_len_i = 0;
   logic [3:0]  req_sel_i = 0;
   logic [31:0] wdat_i = 0;
   logic        wdat_valid_i = 0;
   logic        req_ready_o, wdat_ready_o, rdat_valid_o, done_o, err_o;
   logic [31:0] rdat_o, wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i;
   logic [1:0]  wbm_bte_o;
   logic [2:0]  wbm_cti_o;

   always #5 clk = ~clk;

   wb_b3_burst_master #(.dw(32), .aw(32), .TIMEOUT_CYCLES(16)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_adr_i(req_adr_i), .req_len_i(req_len_i), .req_sel_i(req_sel_i),
      .wdat_i(wdat_i), .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
      .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .done_o(done_o), .err_o(err_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
      .wbm_we_o(wbm_we_o), .wbm_bte_o(wbm_bte_o), .wbm_cti_o(wbm_cti_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
      .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i)
   );

   // RAM slave model
   logic [31:0] mem [0:63];
   logic        no_ack = 1'b0;
   logic        in_ram;
   assign in_ram    = (wbm_adr_o[31:8] == 24'h0);
   assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & in_ram & ~no_ack;
   assign wbm_err_i = wbm_cyc_o & wbm_stb_o & ~in_ram & ~no_ack;
   assign wbm_rty_i = 1'b0;
   assign wbm_dat_i = mem[wbm_adr_o[7:2]];

   always @(posedge clk)
      if (wbm_ack_i && wbm_we_o)
         for (int b = 0; b < 4; b++)
            if (wbm_sel_o[b]) mem[wbm_adr_o[7:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];

   // Bus monitor, sampled on the falling edge
   int n_beat, n_done, n_err, n_rvalid, n_wrdy, n_stb_bad;
   logic [31:0] adr_log[$], rd_log[$];
   logic [2:0]  cti_log[$];
   logic [1:0]  bte_log[$];
   logic [3:0]  sel_log[$];

   always @(negedge clk) begin
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
         n_beat++;
         adr_log.push_back(wbm_adr_o);
         cti_log.push_back(wbm_cti_o);
         bte_log.push_back(wbm_bte_o);
         sel_log.push_back(wbm_sel_o);
      end
      if (rdat_valid_o) begin n_rvalid++; rd_log.push_back(rdat_o); end
      if (done_o) begin n_done++; if (err_o) n_err++; end
      if (wdat_ready_o) n_wrdy++;
      if (wbm_cyc_o && wbm_we_o && (wbm_stb_o != wdat_valid_i)) n_stb_bad++;
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic clear_logs();
      n_beat = 0; n_done = 0; n_err = 0; n_rvalid = 0; n_wrdy = 0; n_stb_bad = 0;
      adr_log.delete(); rd_log.delete(); cti_log.delete(); bte_log.delete(); sel_log.delete();
   endtask

   task automatic send_req(input logic we, input logic [31:0] adr, input logic [1:0] len,
                           input logic [3:0] sel);
      int t = 0;
      @(posedge clk); #1;
      req_valid_i = 1; req_we_i = we; req_adr_i = adr; req_len_i = len; req_sel_i = sel;
      while (!req_ready_o && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) chk("req_ready_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid_i = 0;
   endtask

   task automatic drive_write(input int n, input logic [31:0] base);
      int k = 0, t = 0;
      logic tog = 1'b1;
      while (k < n && t < 200) begin
         wdat_valid_i = tog; wdat_i = base + k;
         @(negedge clk);
         if (wdat_ready_o) k++;
         @(posedge clk); #1;
         tog = ~tog; t++;
      end
      wdat_valid_i = 0; wdat_i = 0;
      if (k < n) chk("wdat_timeout", 0, 1);
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      while (n_done == 0 && t < budget) begin tick(1); t++; end
      if (n_done == 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      clear_logs();

      // Reset state
      #12;
      chk("rst_cyc", wbm_cyc_o, 0);
      chk("rst_stb", wbm_stb_o, 0);
      chk("rst_cti_bte", {wbm_cti_o, wbm_bte_o}, 0);
      chk("rst_ready", req_ready_o, 0);
      chk("rst_done_err", {done_o, err_o, rdat_valid_o, wdat_ready_o}, 0);
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      chk("idle_ready", req_ready_o, 1);

      // Read wrap4 at 0x1C, critical word first
      for (int i = 0; i < 4; i++) mem[4+i] = 32'hA0A0_A000 + i;
      clear_logs();
      send_req(0, 32'h1C, 2'b01, 4'hf);
      wait_done(100);
      tick(3);
      begin
         logic [31:0] exp_adr [4] = '{32'h1C, 32'h10, 32'h14, 32'h18};
         logic [2:0]  exp_cti [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
         logic [31:0] exp_rd  [4] = '{32'hA0A0_A003, 32'hA0A0_A000, 32'hA0A0_A001, 32'hA0A0_A002};
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd4_adr%0d", i), adr_log[i], exp_adr[i]);
            chk($sformatf("rd4_cti%0d", i), cti_log[i], exp_cti[i]);
            chk($sformatf("rd4_dat%0d", i), rd_log[i], exp_rd[i]);
         end
      end
      chk("rd4_bte", bte_log[0], 2'b01);
      chk("rd4_beats", n_beat, 4);
      chk("rd4_rvalid", n_rvalid, 4);
      chk("rd4_done", n_done, 1);
      chk("rd4_err", n_err, 0);

      // Write wrap8 at 0x20 with write data valid toggling
      clear_logs();
      send_req(1, 32'h20, 2'b10, 4'h3);
      drive_write(8, 32'hD000_0000);
      wait_done(100);
      tick(3);
      for (int i = 0; i < 8; i++)
         chk($sformatf("wr8_mem%0d", i), mem[8+i], 32'hD000_0000 + i);
      chk("wr8_wrdy", n_wrdy, 8);
      chk("wr8_beats", n_beat, 8);
      chk("wr8_stb_follows_valid", n_stb_bad, 0);
      chk("wr8_cti_first", cti_log[0], 3'b010);
      chk("wr8_cti_last", cti_log[7], 3'b111);
      chk("wr8_adr_last", adr_log[7], 32'h3C);
      chk("wr8_bte", bte_log[0], 2'b10);
      chk("wr8_sel", sel_log[0], 4'hf);
      chk("wr8_done", n_done, 1);
      chk("wr8_err", n_err, 0);
      chk("wr8_rvalid", n_rvalid, 0);

      // Classic single write, byte lane 1 only
      mem[16] = 32'h1122_3344;
      clear_logs();
      send_req(1, 32'h40, 2'b00, 4'b0010);
      drive_write(1, 32'h0000_AB00);
      wait_done(50);
      tick(2);
      chk("sw_mem", mem[16], 32'h1122_AB44);
      chk("sw_cti", cti_log[0], 3'b000);
      chk("sw_sel", sel_log[0], 4'b0010);
      chk("sw_adr", adr_log[0], 32'h40);
      chk("sw_done", n_done, 1);
      chk("sw_err", n_err, 0);

      // Read outside RAM: slave error on first beat
      clear_logs();
      send_req(0, 32'h0100_0000, 2'b01, 4'hf);
      begin
         int t = 0;
         @(negedge clk);
         while (!(wbm_cyc_o && wbm_stb_o && wbm_err_i) && t < 20) begin @(negedge clk); t++; end
         if (t >= 20) chk("err_seen_timeout", 0, 1);
         @(negedge clk);
         chk("err_cyc_dropped", {wbm_cyc_o, wbm_stb_o}, 2'b00);
         chk("err_done_pulse", {done_o, err_o}, 2'b11);
      end
      tick(3);
      chk("err_rvalid", n_rvalid, 0);
      chk("err_done_count", n_done, 1);
      chk("err_err_count", n_err, 1);

      // Reset during beat 5 of a wrap16 read
      for (int i = 0; i < 16; i++) mem[32+i] = 32'hC000_0000 + i;
      clear_logs();
      send_req(0, 32'h88, 2'b11, 4'hf);
      begin
         int t = 0;
         while (n_beat < 5 && t < 50) begin tick(1); t++; end
         if (t >= 50) chk("beat5_timeout", 0, 1);
      end
      rst_n = 0;
      #1;
      chk("arst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      chk("arst_ready", req_ready_o, 0);
      tick(3);
      chk("arst_no_done", n_done, 0);
      chk("arst_adr4", adr_log[4], 32'h98);
      chk("arst_rd3", rd_log[3], 32'hC000_0005);
      chk("arst_rvalid", n_rvalid, 4);
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      chk("arst_ready_after", req_ready_o, 1);

      for (int i = 0; i < 4; i++) mem[i] = 32'hB000_0000 + i;
      clear_logs();
      send_req(0, 32'h08, 2'b01, 4'hf);
      wait_done(100);
      tick(3);
      begin
         logic [31:0] exp_adr [4] = '{32'h08, 32'h0C, 32'h00, 32'h04};
         logic [31:0] exp_rd  [4] = '{32'hB000_0002, 32'hB000_0003, 32'hB000_0000, 32'hB000_0001};
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_adr%0d", i), adr_log[i], exp_adr[i]);
            chk($sformatf("post_dat%0d", i), rd_log[i], exp_rd[i]);
         end
      end
      chk("post_done", n_done, 1);
      chk("post_err", n_err, 0);

`ifdef WB_B3_BURST_MASTER_TIMEOUT_EN
      // Slave never responds: abort after 16 strobed cycles
      no_ack = 1'b1;
      clear_logs();
      send_req(0, 32'h00, 2'b00, 4'hf);
      begin
         int t = 0, n_stb = 0;
         logic seen_err = 1'b0;
         while (!done_o && t < 100) begin
            @(negedge clk);
            if (wbm_stb_o) n_stb++;
            if (done_o) seen_err = err_o;
            t++;
         end
         if (t >= 100) chk("to_done_timeout", 0, 1);
         chk("to_stb_cycles", n_stb, 16);
         chk("to_err", seen_err, 1);
      end
      tick(2);
      chk("to_done_count", n_done, 1);
      no_ack = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_fail);
      $finish;
   end

endmodule
